// File: rtl/dm_dmi_regs.sv
// Debug Module DMI register front end: decodes DMI requests, holds the DM control and
// abstract-command state, and drives the halt/resume and register-access handshakes to one hart.
module dm_dmi_regs #(
  parameter int          ABITS    = 7,
  parameter int          XLEN     = 32,
  parameter logic [31:0] HARTINFO = 32'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ABITS-1:0] req_addr,
  input  logic [31:0]      req_data,
  input  logic [1:0]       req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [1:0]       rsp_op,
  output logic             haltreq,
  output logic             resumereq,
  output logic             ndmreset,
  input  logic             halted,
  input  logic             resumeack,
  output logic             ar_valid,
  input  logic             ar_ready,
  output logic             ar_write,
  output logic [15:0]      ar_regno,
  output logic [XLEN-1:0]  ar_wdata,
  input  logic             ar_done,
  input  logic             ar_err,
  input  logic [XLEN-1:0]  ar_rdata
);

  localparam logic [ABITS-1:0] A_DATA0      = ABITS'(7'h04);
  localparam logic [ABITS-1:0] A_DMCONTROL  = ABITS'(7'h10);
  localparam logic [ABITS-1:0] A_DMSTATUS   = ABITS'(7'h11);
  localparam logic [ABITS-1:0] A_HARTINFO   = ABITS'(7'h12);
  localparam logic [ABITS-1:0] A_ABSTRACTCS = ABITS'(7'h16);
  localparam logic [ABITS-1:0] A_COMMAND    = ABITS'(7'h17);

  typedef enum logic {IDLE, RSP} rstate_t;
  typedef enum logic [1:0] {CIDLE, CISSUE, CWAIT} cstate_t;

  rstate_t         rstate, rstate_d;
  cstate_t         cstate, cstate_d;

  logic            dmactive;
  logic            haltreq_q, ndmreset_q, resumereq_q, resumeack_q;
  logic [XLEN-1:0] data0;
  logic [2:0]      cmderr, cmderr_d;
  logic            ar_write_q;
  logic [15:0]     ar_regno_q;
  logic [31:0]     rsp_data_q;
  logic [1:0]      rsp_op_q;

  logic            accept, wr_en;
  logic            wr_dmcontrol, wr_data0, wr_abstractcs, wr_command;
  logic            abort, dm_hold, busy, hart_done, start_cmd;
  logic            mapped;
  logic [31:0]     rd_val, dmstatus, abstractcs;
  logic [31:0]     rsp_data_d;
  logic [1:0]      rsp_op_d;

  assign accept        = req_valid && (rstate == IDLE);
  assign wr_en         = accept && (req_op == 2'd2);
  assign wr_dmcontrol  = wr_en && (req_addr == A_DMCONTROL);
  assign wr_data0      = wr_en && (req_addr == A_DATA0);
  assign wr_abstractcs = wr_en && (req_addr == A_ABSTRACTCS);
  assign wr_command    = wr_en && (req_addr == A_COMMAND);

  // Clearing dmactive wipes all DM state in the same cycle the write is accepted
  assign abort     = wr_dmcontrol && !req_data[0];
  assign dm_hold   = !dmactive || abort;
  assign busy      = (cstate != CIDLE);
  assign hart_done = (cstate == CWAIT) && ar_done;

  assign dmstatus   = {14'b0, resumeack_q, resumeack_q, 4'b0, !halted, !halted,
                       halted, halted, 1'b1, 3'b0, 4'd2};
  assign abstractcs = {3'b0, 5'd0, 11'b0, busy, 1'b0, cmderr, 4'b0, 4'd1};

  // Request decode and response formation
  always_comb begin
    rd_val = '0;
    mapped = 1'b1;
    case (req_addr)
      A_DATA0:      rd_val = data0;
      A_DMCONTROL:  rd_val = {haltreq_q, 1'b0, 28'b0, ndmreset_q, dmactive};
      A_DMSTATUS:   rd_val = dmstatus;
      A_HARTINFO:   rd_val = HARTINFO;
      A_ABSTRACTCS: rd_val = abstractcs;
      A_COMMAND:    rd_val = '0;
      default:      mapped = 1'b0;
    endcase
    if (!dmactive && (req_addr != A_DMCONTROL)) rd_val = '0;

    rsp_data_d = '0;
    rsp_op_d   = 2'd0;
    case (req_op)
      2'd1: begin
        if (mapped) rsp_data_d = rd_val;
        else        rsp_op_d   = 2'd2;
      end
      2'd2:    if (!mapped) rsp_op_d = 2'd2;
      2'd3:    rsp_op_d = 2'd2;
      default: ;
    endcase
  end

  always_comb begin
    rstate_d = rstate;
    case (rstate)
      IDLE:    if (req_valid) rstate_d = RSP;
      RSP:     if (rsp_ready) rstate_d = IDLE;
      default: rstate_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rstate     <= IDLE;
      rsp_data_q <= '0;
      rsp_op_q   <= 2'd0;
    end else begin
      rstate <= rstate_d;
      if (accept) begin
        rsp_data_q <= rsp_data_d;
        rsp_op_q   <= rsp_op_d;
      end
    end
  end

  // Abstract command sequencing; hart error lands before the DMI W1C of the same cycle
  always_comb begin
    cstate_d  = cstate;
    cmderr_d  = cmderr;
    start_cmd = 1'b0;
    case (cstate)
      CISSUE:  if (ar_ready) cstate_d = CWAIT;
      CWAIT:   if (ar_done) cstate_d = CIDLE;
      default: ;
    endcase
    if (hart_done && ar_err) cmderr_d = 3'd3;
    if (wr_abstractcs) cmderr_d = cmderr_d & ~req_data[10:8];
    if (busy && (wr_data0 || wr_command)) begin
      if (cmderr_d == 3'd0) cmderr_d = 3'd1;
    end else if (wr_command && (cmderr == 3'd0)) begin
      if ((req_data[31:24] != 8'd0) || (req_data[22:20] != 3'd2)) begin
        cmderr_d = 3'd2;
      end else if (!halted) begin
        cmderr_d = 3'd4;
      end else if (req_data[17]) begin
        start_cmd = 1'b1;
        cstate_d  = CISSUE;
      end
    end
    if (dm_hold) begin
      cstate_d  = CIDLE;
      cmderr_d  = 3'd0;
      start_cmd = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cstate <= CIDLE;
      cmderr <= 3'd0;
    end else begin
      cstate <= cstate_d;
      cmderr <= cmderr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) dmactive <= 1'b0;
    else if (wr_dmcontrol) dmactive <= req_data[0];
  end

  // DM state; everything except dmactive stays cleared while the DM is inactive
  always_ff @(posedge clk) begin
    if (rst || dm_hold) begin
      haltreq_q   <= 1'b0;
      ndmreset_q  <= 1'b0;
      resumereq_q <= 1'b0;
      resumeack_q <= 1'b0;
      data0       <= '0;
      ar_write_q  <= 1'b0;
      ar_regno_q  <= '0;
    end else begin
      resumereq_q <= wr_dmcontrol && req_data[30];
      if (wr_dmcontrol) begin
        haltreq_q  <= req_data[31];
        ndmreset_q <= req_data[1];
      end
      if (wr_dmcontrol && req_data[30]) resumeack_q <= 1'b0;
      else if (resumeack)               resumeack_q <= 1'b1;
      if (wr_data0 && !busy)                       data0 <= req_data;
      else if (hart_done && !ar_err && !ar_write_q) data0 <= ar_rdata;
      if (start_cmd) begin
        ar_write_q <= req_data[16];
        ar_regno_q <= req_data[15:0];
      end
    end
  end

  assign req_ready = (rstate == IDLE);
  assign rsp_valid = (rstate == RSP);
  assign rsp_data  = rsp_data_q;
  assign rsp_op    = rsp_op_q;
  assign haltreq   = haltreq_q;
  assign ndmreset  = ndmreset_q;
  assign resumereq = resumereq_q;
  assign ar_valid  = (cstate == CISSUE) && !abort;
  assign ar_write  = ar_write_q;
  assign ar_regno  = ar_regno_q;
  assign ar_wdata  = data0;

endmodule

// File: tb/tb_dm_dmi_regs.sv
// Bench for dm_dmi_regs: directed register scenarios followed by random DMI/hart traffic
// checked against a register-level model of the Debug Module.
module tb_dm_dmi_regs;

  localparam logic [31:0] HARTINFO_EXP = 32'h0;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, rsp_valid, rsp_ready;
  logic [6:0]  req_addr;
  logic [31:0] req_data, rsp_data;
  logic [1:0]  req_op, rsp_op;
  logic        haltreq, resumereq, ndmreset, halted, resumeack;
  logic        ar_valid, ar_ready, ar_write, ar_done, ar_err;
  logic [15:0] ar_regno;
  logic [31:0] ar_wdata, ar_rdata;

  always #5 clk = ~clk;

  dm_dmi_regs dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_op(rsp_op),
    .haltreq(haltreq), .resumereq(resumereq), .ndmreset(ndmreset),
    .halted(halted), .resumeack(resumeack),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_write(ar_write), .ar_regno(ar_regno),
    .ar_wdata(ar_wdata), .ar_done(ar_done), .ar_err(ar_err), .ar_rdata(ar_rdata)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  bit          m_act, m_halt, m_ndm, m_rack, m_busy, m_iss, m_pw;
  logic [15:0] m_preg;
  logic [31:0] m_data0;
  logic [2:0]  m_cerr;

  bit          co_done, co_err;
  logic [31:0] co_rdata;
  logic [31:0] last_rd;
  logic [1:0]  last_op;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_halt = 0; m_ndm = 0; m_rack = 0; m_busy = 0; m_iss = 0; m_pw = 0;
    m_preg = 0; m_data0 = 0; m_cerr = 0;
  endtask

  function automatic bit is_mapped(input logic [6:0] a);
    return (a == 7'h04) || (a == 7'h10) || (a == 7'h11) || (a == 7'h12) ||
           (a == 7'h16) || (a == 7'h17);
  endfunction

  function automatic logic [31:0] model_read(input logic [6:0] a);
    logic [31:0] v;
    v = 0;
    if (a == 7'h10) return (m_halt ? 32'h8000_0000 : 0) + (m_ndm ? 32'd2 : 0) + (m_act ? 32'd1 : 0);
    if (!m_act) return 0;
    case (a)
      7'h04: v = m_data0;
      7'h11: v = 32'd2 + 32'd128 + (halted ? 32'h300 : 32'hC00) + (m_rack ? 32'h3_0000 : 0);
      7'h12: v = HARTINFO_EXP;
      7'h16: v = 32'd1 + (32'(m_cerr) * 256) + (m_busy ? 32'h1000 : 0);
      default: v = 0;
    endcase
    return v;
  endfunction

  task automatic model_write(input logic [6:0] a, input logic [31:0] wd, output bit rr);
    rr = 0;
    case (a)
      7'h10: begin
        if (!m_act) m_act = wd[0];
        else if (!wd[0]) model_reset();
        else begin
          m_halt = wd[31]; m_ndm = wd[1];
          if (wd[30]) begin m_rack = 0; rr = 1; end
        end
      end
      7'h04: if (m_act) begin
        if (m_busy) begin if (m_cerr == 0) m_cerr = 1; end
        else m_data0 = wd;
      end
      7'h16: if (m_act) m_cerr = m_cerr & ~wd[10:8];
      7'h17: if (m_act) begin
        if (m_busy) begin if (m_cerr == 0) m_cerr = 1; end
        else if (m_cerr != 0) ;
        else if (wd[31:24] != 0 || wd[22:20] != 3'd2) m_cerr = 2;
        else if (!halted) m_cerr = 4;
        else if (wd[17]) begin m_busy = 1; m_iss = 0; m_pw = wd[16]; m_preg = wd[15:0]; end
      end
      default: ;
    endcase
  endtask

  task automatic model_hart_done(input bit err, input logic [31:0] rd);
    if (m_iss) begin
      m_busy = 0; m_iss = 0;
      if (err) m_cerr = 3;
      else if (!m_pw) m_data0 = rd;
    end
  endtask

  task automatic check_outputs();
    chk("haltreq", 32'(haltreq), 32'(m_halt));
    chk("ndmreset", 32'(ndmreset), 32'(m_ndm));
    chk("ar_valid", 32'(ar_valid), 32'(m_busy && !m_iss));
  endtask

  // One DMI transaction with optional response back-pressure
  task automatic dmi(input logic [1:0] op, input logic [6:0] a, input logic [31:0] wd, input int stall);
    logic [31:0] exp_d, held;
    logic [1:0]  exp_o;
    bit          rr;
    exp_d = 0; exp_o = 0; rr = 0;
    if (op == 2'd3 || ((op == 2'd1 || op == 2'd2) && !is_mapped(a))) exp_o = 2;
    else if (op == 2'd1) exp_d = model_read(a);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1; req_op = op; req_addr = a; req_data = wd;
    rsp_ready = (stall == 0);
    if (co_done) begin ar_done = 1; ar_err = co_err; ar_rdata = co_rdata; end
    @(posedge clk); #1;
    req_valid = 0; req_addr = 7'($urandom); req_data = $urandom; req_op = 2'($urandom);
    ar_done = 0; ar_err = 0;
    if (co_done) model_hart_done(co_err, co_rdata);
    if (op == 2'd2 && is_mapped(a)) model_write(a, wd, rr);
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_data", rsp_data, exp_d);
    chk("rsp_op", 32'(rsp_op), 32'(exp_o));
    chk("resumereq_pulse", 32'(resumereq), 32'(rr));
    last_rd = rsp_data; last_op = rsp_op; held = rsp_data;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rsp_data", rsp_data, held);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    chk("rsp_done", 32'(rsp_valid), 32'd0);
    chk("req_ready_back", 32'(req_ready), 32'd1);
    chk("resumereq_low", 32'(resumereq), 32'd0);
    check_outputs();
  endtask

  task automatic hart_accept(input int delay);
    for (int i = 0; i < delay; i++) begin @(posedge clk); #1; end
    chk("ar_valid_issue", 32'(ar_valid), 32'd1);
    chk("ar_write", 32'(ar_write), 32'(m_pw));
    chk("ar_regno", 32'(ar_regno), 32'(m_preg));
    chk("ar_wdata", ar_wdata, m_data0);
    ar_ready = 1;
    @(posedge clk); #1;
    ar_ready = 0;
    m_iss = 1;
    chk("ar_valid_after_ready", 32'(ar_valid), 32'd0);
  endtask

  task automatic hart_done(input bit err, input logic [31:0] rd);
    ar_done = 1; ar_err = err; ar_rdata = rd;
    @(posedge clk); #1;
    ar_done = 0; ar_err = 0; ar_rdata = $urandom;
    model_hart_done(err, rd);
    check_outputs();
  endtask

  task automatic pulse_resumeack();
    resumeack = 1;
    @(posedge clk); #1;
    resumeack = 0;
    if (m_act) m_rack = 1;
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset();
  endtask

  logic [6:0]  addrs [6] = '{7'h04, 7'h10, 7'h11, 7'h12, 7'h16, 7'h17};
  logic [31:0] wd;

  initial begin
    rst = 1; req_valid = 0; req_addr = 0; req_data = 0; req_op = 0; rsp_ready = 1;
    halted = 0; resumeack = 0; ar_ready = 0; ar_done = 0; ar_err = 0; ar_rdata = 0;
    co_done = 0; co_err = 0; co_rdata = 0;
    @(posedge clk); #1;
    do_reset();

    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_haltreq", 32'(haltreq), 32'd0);
    chk("rst_resumereq", 32'(resumereq), 32'd0);
    chk("rst_ndmreset", 32'(ndmreset), 32'd0);
    chk("rst_ar_valid", 32'(ar_valid), 32'd0);
    chk("rst_ar_regno", 32'(ar_regno), 32'd0);
    chk("rst_ar_wdata", ar_wdata, 32'd0);

    // Activation and status
    dmi(2, 7'h10, 32'h1, 0);
    dmi(1, 7'h11, 0, 0);
    chk("dmstatus_running", last_rd, 32'h0000_0C82);
    dmi(2, 7'h10, 32'h8000_0001, 0);
    chk("haltreq_set", 32'(haltreq), 32'd1);
    halted = 1;
    dmi(1, 7'h11, 0, 0);
    chk("dmstatus_halted", last_rd, 32'h0000_0382);

    // Write-register command
    dmi(2, 7'h04, 32'hDEAD_BEEF, 0);
    dmi(2, 7'h17, 32'h0023_0008, 0);
    chk("cmd_ar_write", 32'(ar_write), 32'd1);
    chk("cmd_ar_regno", 32'(ar_regno), 32'd8);
    chk("cmd_ar_wdata", ar_wdata, 32'hDEAD_BEEF);
    dmi(1, 7'h16, 0, 0);
    chk("abstractcs_busy", last_rd, 32'h0000_1001);
    hart_accept(1);
    hart_done(0, 32'h0);

    // Read-register command
    dmi(2, 7'h17, 32'h0022_1001, 0);
    hart_accept(0);
    hart_done(0, 32'h1234_5678);
    dmi(1, 7'h04, 0, 0);
    chk("data0_readback", last_rd, 32'h1234_5678);

    // cmderr: busy, W1C, not halted
    dmi(2, 7'h17, 32'h0023_0008, 0);
    dmi(2, 7'h17, 32'h0023_0008, 0);
    hart_accept(0);
    hart_done(0, 32'h0);
    dmi(1, 7'h16, 0, 0);
    chk("cmderr_busy", last_rd, 32'h0000_0101);
    dmi(2, 7'h16, 32'h700, 0);
    dmi(1, 7'h16, 0, 0);
    chk("cmderr_cleared", last_rd, 32'h0000_0001);
    halted = 0;
    dmi(2, 7'h17, 32'h0023_0008, 0);
    dmi(1, 7'h16, 0, 0);
    chk("cmderr_not_halted", last_rd, 32'h0000_0401);
    dmi(2, 7'h16, 32'h700, 0);
    halted = 1;

    // Back-pressure and unmapped
    dmi(1, 7'h10, 0, 5);
    chk("stalled_dmcontrol", last_rd, 32'h8000_0001);
    dmi(1, 7'h7F, 0, 0);
    chk("unmapped_op", 32'(last_op), 32'd2);

    // Hart error coinciding with W1C
    dmi(2, 7'h17, 32'h0022_1005, 0);
    hart_accept(0);
    co_done = 1; co_err = 1; co_rdata = 32'hAAAA_5555;
    dmi(2, 7'h16, 32'h100, 0);
    co_done = 0;
    dmi(1, 7'h16, 0, 0);
    chk("err_then_w1c_partial", last_rd, 32'h0000_0201);
    dmi(2, 7'h16, 32'h700, 0);
    dmi(2, 7'h17, 32'h0022_1005, 0);
    hart_accept(0);
    co_done = 1;
    dmi(2, 7'h16, 32'h300, 0);
    co_done = 0;
    dmi(1, 7'h16, 0, 0);
    chk("err_then_w1c_full", last_rd, 32'h0000_0001);

    // Abort by clearing dmactive while a command is issued
    dmi(2, 7'h17, 32'h0023_0009, 0);
    dmi(2, 7'h10, 32'h0, 0);
    chk("abort_ar_valid", 32'(ar_valid), 32'd0);
    dmi(1, 7'h16, 0, 0);
    chk("inactive_abstractcs", last_rd, 32'h0);
    dmi(2, 7'h10, 32'h8000_0003, 0);
    chk("inactive_haltreq_held", 32'(haltreq), 32'd0);
    dmi(2, 7'h10, 32'h8000_0001, 0);

    // Resume request / sticky resumeack
    dmi(2, 7'h10, 32'h4000_0001, 0);
    pulse_resumeack();
    dmi(1, 7'h11, 0, 0);
    chk("resumeack_sticky", last_rd, 32'h0003_0382);
    dmi(2, 7'h10, 32'h4000_0001, 0);
    dmi(1, 7'h11, 0, 0);
    chk("resumeack_cleared", last_rd, 32'h0000_0382);

    // Reset during a pending response with a command issued
    dmi(2, 7'h17, 32'h0023_0002, 0);
    req_valid = 1; req_op = 1; req_addr = 7'h10; rsp_ready = 0;
    @(posedge clk); #1;
    req_valid = 0;
    chk("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0; rsp_ready = 1;
    model_reset();
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_ar_valid", 32'(ar_valid), 32'd0);
    chk("mid_rst_haltreq", 32'(haltreq), 32'd0);

    // Random traffic
    dmi(2, 7'h10, 32'h1, 0);
    for (int it = 0; it < 500; it++) begin
      case ($urandom_range(0, 11))
        0: begin
          wd = $urandom;
          wd[0] = ($urandom_range(0, 9) != 0);
          dmi(2, 7'h10, wd, 0);
        end
        1, 2: dmi(1, addrs[$urandom_range(0, 5)], 0, $urandom_range(0, 2));
        3: dmi(2, 7'h04, $urandom, 0);
        4, 5: begin
          wd = $urandom;
          if ($urandom_range(0, 9) != 0) wd[31:24] = 0;
          if ($urandom_range(0, 6) != 0) wd[22:20] = 3'd2;
          wd[17] = ($urandom_range(0, 4) != 0);
          dmi(2, 7'h17, wd, 0);
        end
        6, 11: begin
          if (m_busy && !m_iss) hart_accept($urandom_range(0, 2));
          else hart_done($urandom_range(0, 3) == 0, $urandom);
        end
        7: begin
          halted = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
          check_outputs();
        end
        8: pulse_resumeack();
        9: dmi(2, 7'h16, $urandom, 0);
        default: dmi(2'($urandom), 7'($urandom), $urandom, 0);
      endcase
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
